digit_scan_ctrl: RTL and testbench
==================================

// Module: digit_scan_ctrl
// PURPOSE
//  Sequential upstream stage for the 3-8 decoder. Generates the 3-bit select code A2..A1..A0 that drives decoder_3_8.
//  Steps through the enabled decoder outputs, either on a timed auto-scan or on single-step pulses.
//  Inserts blanking cycles on every select change, so downstream one-hot lines (digit/LED enables) never ghost.
//  The A outputs connect straight to decoder_3_8 A0/A1/A2. The blank output gates the decoder's Y lines.
// PARAMETERS
//  TICK_DIV   50000  dwell time of each index in SHOW, in sys_clk cycles (>=2); applies when run=1
//  BLANK_CYC  4      blank cycles inserted after every index change (>=1)
// PORTS
//  sys_clk   in   1  system clock, rising edge
//  sys_rst   in   1  asynchronous, active-high reset
//  run       in   1  1 = auto-scan using TICK_DIV; 0 = manual, advance on step
//  step      in   1  single-cycle advance pulse; used only when run=0
//  mask      in   8  bit i = 1 enables index i; disabled indices are skipped
//  A0        out  1  select bit 0 (LSB) to decoder
//  A1        out  1  select bit 1 to decoder
//  A2        out  1  select bit 2 (MSB) to decoder
//  blank     out  1  1 = decoder outputs must be suppressed
//  wrap      out  1  one-cycle pulse when the index wraps (new idx <= old idx on a change)
// BEHAVIOUR
//  Reset (async, immediate): idx=0 so {A2,A1,A0}=3'b000; blank=1; wrap=0; state=IDLE; dwell and blank counters=0.
//  All outputs are registered, and {A2,A1,A0} always equals the internal idx.
//  next_idx: first set mask bit searched cyclically from idx+1 through idx+7, then idx itself (mod 8).
//  States:
//   IDLE  : blank=1, idx held. When mask!=0: idx <= lowest set mask bit; go to BLANK; blank counter=0.
//   BLANK : blank=1. Counts BLANK_CYC cycles, then goes to SHOW with dwell=0; step is ignored here.
//   SHOW  : blank=0.
//           dwell increments each cycle while run=1 and is cleared while run=0.
//           An advance event is any of:
//            - run=1 and dwell==TICK_DIV-1
//            - run=0 and step=1
//            - mask[idx]==0 (forced advance)
//           On advance, if next_idx!=idx: idx <= next_idx, go to BLANK, and pulse wrap if next_idx<=idx.
//           On advance, if next_idx==idx (single enabled bit): dwell=0, stay in SHOW, no blank, no wrap.
//  From any state: mask==0 gives IDLE on the next edge (blank=1 that cycle); idx is held. Mask zero has priority over advance.
//  Simultaneous step and run=1: step is ignored. A step that arrives in the same cycle as a timed advance produces only one advance.
//  Visible SHOW time per index is TICK_DIV cycles; the period per index is BLANK_CYC+TICK_DIV cycles.
//  wrap asserts in the same cycle that idx updates and lasts exactly one cycle.
//  Reset asserted mid-SHOW or mid-BLANK: outputs go to reset values with no clock edge needed.
//   After release, the block restarts from IDLE.
// TESTING (TICK_DIV=4, BLANK_CYC=2 in bench; instantiate decoder_3_8 downstream and check one-hot Y gated by blank)
//  1 Full scan: mask=8'hFF, run=1
//    -> idx 0,1,...,7,0; each index shows 2 blank cycles then 4 SHOW cycles; wrap pulses once on 7->0; Y one-hot when blank=0.
//  2 Sparse mask: mask=8'b1010_0100, run=1
//    -> idx 2,5,7,2,...; wrap only on 7->2; indices 0,1,3,4,6 never appear.
//  3 Manual: run=0, mask=8'hFF, three step pulses in SHOW plus one step during BLANK
//    -> idx advances 0->1->2->3; the step during BLANK has no effect; dwell never advances idx.
//  4 Single bit: mask=8'h10, run=1
//    -> idx=4 after initial blank; blank stays 0 thereafter; wrap never asserts.
//  5 Mask drop/restore: in SHOW at idx=3, mask<=0
//    -> blank=1 next cycle, state IDLE, A stays 3'b011.
//    Then mask<=8'h01 -> idx=0 after 2 blank cycles.
//  6 Async reset mid-scan: sys_rst=1 at idx=5 between clock edges
//    -> A=3'b000, blank=1, wrap=0 immediately. After release with mask=8'hFF -> rescan starts at idx 0.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// Select-code sequencer for a 3-8 decoder.
// Supports timed or stepped scanning with blanking on every select change.
module digit_scan_ctrl #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] mask,
    output logic       A0,
    output logic       A1,
    output logic       A2,
    output logic       blank,
    output logic       wrap
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            blank_q, blank_d;
    logic            wrap_q, wrap_d;

    logic [2:0]      nxt_idx;
    logic [2:0]      low_idx;
    logic            found;
    logic            advance;

    // Cyclic search from idx+1 around to idx itself.
    always_comb begin
        nxt_idx = idx_q;
        found   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && mask[idx_q + 3'(k)]) begin
                nxt_idx = idx_q + 3'(k);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    assign advance = (run && (dwell_q == DW'(TICK_DIV - 1)))
                   || (!run && step)
                   || !mask[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        bcnt_d  = bcnt_q;
        wrap_d  = 1'b0;
        if (mask == 8'h00) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    idx_d   = low_idx;
                    state_d = ST_BLANK;
                    bcnt_d  = '0;
                end
                ST_BLANK: begin
                    if (bcnt_q == BW'(BLANK_CYC - 1)) begin
                        state_d = ST_SHOW;
                        dwell_d = '0;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
                ST_SHOW: begin
                    dwell_d = run ? dwell_q + DW'(1) : '0;
                    if (advance) begin
                        if (nxt_idx != idx_q) begin
                            idx_d   = nxt_idx;
                            state_d = ST_BLANK;
                            bcnt_d  = '0;
                            wrap_d  = (nxt_idx <= idx_q);
                        end else begin
                            dwell_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        blank_d = (state_d != ST_SHOW);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            dwell_q <= '0;
            bcnt_q  <= '0;
            blank_q <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            bcnt_q  <= bcnt_d;
            blank_q <= blank_d;
            wrap_q  <= wrap_d;
        end
    end

    assign {A2, A1, A0} = idx_q;
    assign blank        = blank_q;
    assign wrap         = wrap_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with a behavioural 3-8 decoder
// downstream; TICK_DIV=4, BLANK_CYC=2.
module tb_digit_scan_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       run     = 1'b0;
    logic       step    = 1'b0;
    logic [7:0] mask    = 8'h00;
    logic       A0, A1, A2, blank, wrap;
    logic [7:0] y;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    digit_scan_ctrl #(
        .TICK_DIV (4),
        .BLANK_CYC(2)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .run    (run),
        .step   (step),
        .mask   (mask),
        .A0     (A0),
        .A1     (A1),
        .A2     (A2),
        .blank  (blank),
        .wrap   (wrap)
    );

    // Downstream decoder with Y lines gated by blank.
    assign y = blank ? 8'h00 : (8'h01 << {A2, A1, A0});

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] a,
                           input logic b, input logic w);
        chk({tag, ".A"}, {5'd0, A2, A1, A0}, {5'd0, a});
        chk({tag, ".blank"}, {7'd0, blank}, {7'd0, b});
        chk({tag, ".wrap"}, {7'd0, wrap}, {7'd0, w});
    endtask

    // One full index period: 2 blank cycles then 4 visible cycles.
    task automatic scan_idx(input string tag, input logic [2:0] k,
                            input logic exp_wrap);
        @(negedge sys_clk);
        chk_out({tag, ".b0"}, k, 1'b1, exp_wrap);
        @(negedge sys_clk);
        chk_out({tag, ".b1"}, k, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            chk_out({tag, ".show"}, k, 1'b0, 1'b0);
            chk({tag, ".Y"}, y, 8'h01 << k);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        mask    = 8'h00;
        run     = 1'b0;
        step    = 1'b0;
        @(negedge sys_clk);
        chk_out("rst", 3'd0, 1'b1, 1'b0);
        chk("rst.Y", y, 8'h00);
        sys_rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge sys_clk);
        chk_out("por", 3'd0, 1'b1, 1'b0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk_out("idle_nomask", 3'd0, 1'b1, 1'b0);

        // 1: full scan, wrap only on 7->0
        mask = 8'hFF;
        run  = 1'b1;
        scan_idx("full0", 3'd0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            scan_idx("full", 3'(k), 1'b0);
        end
        scan_idx("fullwrap", 3'd0, 1'b1);

        // 2: sparse mask 2,5,7
        mask = 8'b1010_0100;
        scan_idx("sp2", 3'd2, 1'b0);
        scan_idx("sp5", 3'd5, 1'b0);
        scan_idx("sp7", 3'd7, 1'b0);
        scan_idx("sp2w", 3'd2, 1'b1);
        scan_idx("sp5b", 3'd5, 1'b0);

        // 3: manual stepping, step in blank ignored
        do_reset();
        mask = 8'hFF;
        run  = 1'b0;
        @(negedge sys_clk);
        chk_out("man.b0", 3'd0, 1'b1, 1'b0);
        @(negedge sys_clk);
        chk_out("man.b1", 3'd0, 1'b1, 1'b0);
        @(negedge sys_clk);
        chk_out("man.show0", 3'd0, 1'b0, 1'b0);
        repeat (10) @(negedge sys_clk);
        chk_out("man.hold0", 3'd0, 1'b0, 1'b0);
        step = 1'b1;
        @(negedge sys_clk);
        step = 1'b0;
        chk_out("man.to1", 3'd1, 1'b1, 1'b0);
        step = 1'b1;
        @(negedge sys_clk);
        step = 1'b0;
        chk_out("man.blankstep", 3'd1, 1'b1, 1'b0);
        @(negedge sys_clk);
        chk_out("man.show1", 3'd1, 1'b0, 1'b0);
        step = 1'b1;
        @(negedge sys_clk);
        step = 1'b0;
        chk_out("man.to2", 3'd2, 1'b1, 1'b0);
        repeat (2) @(negedge sys_clk);
        chk_out("man.show2", 3'd2, 1'b0, 1'b0);
        step = 1'b1;
        @(negedge sys_clk);
        step = 1'b0;
        chk_out("man.to3", 3'd3, 1'b1, 1'b0);
        repeat (2) @(negedge sys_clk);
        chk_out("man.show3", 3'd3, 1'b0, 1'b0);
        repeat (6) @(negedge sys_clk);
        chk_out("man.hold3", 3'd3, 1'b0, 1'b0);

        // 4: single enabled bit never blanks or wraps
        do_reset();
        mask = 8'h10;
        run  = 1'b1;
        @(negedge sys_clk);
        chk_out("one.b0", 3'd4, 1'b1, 1'b0);
        @(negedge sys_clk);
        chk_out("one.b1", 3'd4, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge sys_clk);
            chk_out("one.show", 3'd4, 1'b0, 1'b0);
        end

        // 5: mask drop at idx 3 then restore
        do_reset();
        mask = 8'h08;
        run  = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk_out("drop.pre", 3'd3, 1'b0, 1'b0);
        mask = 8'h00;
        @(negedge sys_clk);
        chk_out("drop.idle", 3'd3, 1'b1, 1'b0);
        chk("drop.Y", y, 8'h00);
        repeat (3) @(negedge sys_clk);
        chk_out("drop.hold", 3'd3, 1'b1, 1'b0);
        mask = 8'h01;
        @(negedge sys_clk);
        chk_out("rest.b0", 3'd0, 1'b1, 1'b0);
        @(negedge sys_clk);
        chk_out("rest.b1", 3'd0, 1'b1, 1'b0);
        @(negedge sys_clk);
        chk_out("rest.show", 3'd0, 1'b0, 1'b0);

        // 6: asynchronous reset in SHOW at idx 5
        do_reset();
        mask = 8'hFF;
        run  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            scan_idx("ar", 3'(k), 1'b0);
        end
        repeat (3) @(negedge sys_clk);
        chk_out("ar.at5", 3'd5, 1'b0, 1'b0);
        #2 sys_rst = 1'b1;
        #1;
        chk_out("ar.async", 3'd0, 1'b1, 1'b0);
        chk("ar.Y", y, 8'h00);
        repeat (2) @(negedge sys_clk);
        chk_out("ar.held", 3'd0, 1'b1, 1'b0);
        sys_rst = 1'b0;
        scan_idx("ar.re0", 3'd0, 1'b0);
        scan_idx("ar.re1", 3'd1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
